// File: rtl/mips_lite_pkg.sv
// Shared opcode/ALU encodings and the ID/EX control bundle for the MIPS-lite core.
package mips_lite_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_SLT   = 3'd4;
  localparam logic [2:0] ALU_FUNCT = 3'd7;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       alu_src;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
    logic [2:0] alu_op;
  } id_ex_ctrl_t;

  localparam id_ex_ctrl_t BUBBLE = '0;

endpackage

// File: rtl/immed_extend.sv
// 16-to-32-bit immediate extender: zero-extends when zero_sel is set, else sign-extends.
module immed_extend (
  input  logic [15:0] immed_in,
  input  logic        zero_sel,
  output logic [31:0] immed_out
);

  assign immed_out = zero_sel ? {16'h0000, immed_in} : {{16{immed_in[15]}}, immed_in};

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage plus ID/EX pipeline register with load-use stall, flush and hold.
// Optional ZERO_EXT_LOGICAL_EN: andi/ori zero-extend their immediate.
module id_ex_stage
  import mips_lite_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] instr,
  input  logic [31:0] pc_plus4,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        flush,
  input  logic        hold,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic        stall_out,
  output logic        ex_valid,
  output logic [31:0] ex_pc_plus4,
  output logic [31:0] ex_rs_data,
  output logic [31:0] ex_rt_data,
  output logic [31:0] ex_immed,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_jump,
  output logic        ex_alu_src,
  output logic        ex_reg_dst,
  output logic        ex_mem_to_reg,
  output logic        ex_illegal,
  output logic [2:0]  ex_alu_op
);

  logic [5:0]  opcode;
  id_ex_ctrl_t dec_ctrl;
  id_ex_ctrl_t ctrl_q;
  logic        uses_rt;
  logic        zero_sel;
  logic        hazard;
  logic [31:0] dec_immed;

  assign opcode  = instr[31:26];
  assign rs_addr = instr[25:21];
  assign rt_addr = instr[20:16];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    dec_ctrl = BUBBLE;
    uses_rt  = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        dec_ctrl.reg_dst   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = ALU_FUNCT;
        uses_rt            = 1'b1;
      end
      OP_J:    dec_ctrl.jump = 1'b1;
      OP_BEQ: begin
        dec_ctrl.branch = 1'b1;
        dec_ctrl.alu_op = ALU_SUB;
        uses_rt         = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_ORI: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.alu_op    = (opcode == OP_ANDI) ? ALU_AND :
                             (opcode == OP_ORI)  ? ALU_OR  : ALU_ADD;
      end
      OP_LW: begin
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        dec_ctrl.alu_op     = ALU_ADD;
      end
      OP_SW: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        dec_ctrl.alu_op    = ALU_ADD;
        uses_rt            = 1'b1;
      end
      default: dec_ctrl.illegal = 1'b1;
    endcase
  end

`ifdef ZERO_EXT_LOGICAL_EN
  assign zero_sel = (opcode == OP_ANDI) || (opcode == OP_ORI);
`else
  assign zero_sel = 1'b0;
`endif

  immed_extend u_immed_extend (
    .immed_in  (instr[15:0]),
    .zero_sel  (zero_sel),
    .immed_out (dec_immed)
  );

  // A load in EX cannot forward to the instruction now in ID; $0 reads never depend on it.
  assign hazard = ex_valid && ctrl_q.mem_read && (ex_rt != 5'd0) && if_valid &&
                  ((ex_rt == rs_addr) || (uses_rt && (ex_rt == rt_addr)));

  assign stall_out = hold | (hazard & ~flush);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ctrl_q      <= BUBBLE;
      ex_pc_plus4 <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_immed    <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
    end else if (flush) begin
      ex_valid <= 1'b0;
      ctrl_q   <= BUBBLE;
    end else if (hold) begin
      ex_valid <= ex_valid;
    end else if (hazard) begin
      ex_valid <= 1'b0;
      ctrl_q   <= BUBBLE;
    end else begin
      ex_valid    <= if_valid;
      ctrl_q      <= if_valid ? dec_ctrl : BUBBLE;
      ex_pc_plus4 <= pc_plus4;
      ex_rs_data  <= rs_data;
      ex_rt_data  <= rt_data;
      ex_immed    <= dec_immed;
      ex_rs       <= instr[25:21];
      ex_rt       <= instr[20:16];
      ex_rd       <= instr[15:11];
    end
  end

  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_branch     = ctrl_q.branch;
  assign ex_jump       = ctrl_q.jump;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_reg_dst    = ctrl_q.reg_dst;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_illegal    = ctrl_q.illegal;
  assign ex_alu_op     = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus randomized traffic against
// an instruction-level reference model. Honors ZERO_EXT_LOGICAL_EN like the design.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, if_valid, flush, hold;
  logic [31:0] instr, pc_plus4, rs_data, rt_data;
  logic [4:0]  rs_addr, rt_addr;
  logic        stall_out, ex_valid;
  logic [31:0] ex_pc_plus4, ex_rs_data, ex_rt_data, ex_immed;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump;
  logic        ex_alu_src, ex_reg_dst, ex_mem_to_reg, ex_illegal;
  logic [2:0]  ex_alu_op;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .instr(instr), .pc_plus4(pc_plus4),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush), .hold(hold),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .stall_out(stall_out), .ex_valid(ex_valid),
    .ex_pc_plus4(ex_pc_plus4), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_immed(ex_immed), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_alu_src(ex_alu_src),
    .ex_reg_dst(ex_reg_dst), .ex_mem_to_reg(ex_mem_to_reg), .ex_illegal(ex_illegal),
    .ex_alu_op(ex_alu_op)
  );

  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
    logic        rw, mr, mw, br, jp, as, rdst, m2r, ill;
    logic [2:0]  aop;
  } st_t;

  int   vectors = 0;
  int   miscompares = 0;
  st_t  m;             // model of the ID/EX latch
  logic exp_stall, seen_stall;
  logic [9:0] seen_addr;

  function automatic st_t observed();
    st_t s;
    s = '{ex_valid, ex_pc_plus4, ex_rs_data, ex_rt_data, ex_immed, ex_rs, ex_rt, ex_rd,
          ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src,
          ex_reg_dst, ex_mem_to_reg, ex_illegal, ex_alu_op};
    return s;
  endfunction

  // Data fields of a bubble carry no meaning; only valid and controls are compared then.
  function automatic st_t masked(st_t s);
    st_t r = s;
    if (!r.valid) begin
      r.pc = '0; r.rsd = '0; r.rtd = '0; r.imm = '0; r.rs = '0; r.rt = '0; r.rd = '0;
    end
    return r;
  endfunction

  function automatic st_t ref_decode(logic [31:0] ins, logic [31:0] pc, logic [31:0] a,
                                     logic [31:0] b, logic v);
    st_t s = '0;
    logic [5:0] op = ins[31:26];
    int simm = $signed(ins[15:0]);
    s.valid = v; s.pc = pc; s.rsd = a; s.rtd = b;
    s.rs = ins[25:21]; s.rt = ins[20:16]; s.rd = ins[15:11];
    s.imm = simm;
`ifdef ZERO_EXT_LOGICAL_EN
    if (op == 6'h0C || op == 6'h0D) s.imm = {16'h0, ins[15:0]};
`endif
    if (v) begin
      case (op)
        6'h00: begin s.rdst = 1; s.rw = 1; s.aop = 7; end
        6'h02: s.jp = 1;
        6'h04: begin s.br = 1; s.aop = 1; end
        6'h08: begin s.as = 1; s.rw = 1; s.aop = 0; end
        6'h0C: begin s.as = 1; s.rw = 1; s.aop = 2; end
        6'h0D: begin s.as = 1; s.rw = 1; s.aop = 3; end
        6'h23: begin s.as = 1; s.mr = 1; s.m2r = 1; s.rw = 1; s.aop = 0; end
        6'h2B: begin s.as = 1; s.mw = 1; s.aop = 0; end
        default: s.ill = 1;
      endcase
    end
    return s;
  endfunction

  function automatic logic reads_rt(logic [5:0] op);
    return op == 6'h00 || op == 6'h04 || op == 6'h2B;
  endfunction

  // Samples combinational outputs before the edge, advances the model, and lands #1 after the edge.
  task automatic step();
    logic hz;
    st_t  bub;
    #1;
    hz = m.valid && m.mr && m.rt != 0 && if_valid &&
         (m.rt == instr[25:21] || (reads_rt(instr[31:26]) && m.rt == instr[20:16]));
    exp_stall  = hold | (hz & ~flush);
    seen_stall = stall_out;
    seen_addr  = {rs_addr, rt_addr};
    bub = m; bub.valid = 0;
    {bub.rw, bub.mr, bub.mw, bub.br, bub.jp, bub.as, bub.rdst, bub.m2r, bub.ill, bub.aop} = '0;
    if (rst)        m = '0;
    else if (flush) m = bub;
    else if (hold)  m = m;
    else if (hz)    m = bub;
    else            m = ref_decode(instr, pc_plus4, rs_data, rt_data, if_valid);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic [31:0] ins, logic v);
    instr = ins; if_valid = v;
    pc_plus4 = $urandom; rs_data = $urandom; rt_data = $urandom;
  endtask

  task automatic test_reset();
    rst = 1; hold = 0; flush = 0; drive($urandom, 1);
    step(); step();
    vectors++;
    if (observed() !== st_t'('0)) begin
      miscompares++; $display("FAIL reset_outputs: got %h want 0", observed());
    end
    vectors++;
    if (stall_out !== 1'b0) begin
      miscompares++; $display("FAIL reset_stall: got %b want 0", stall_out);
    end
    rst = 0;
  endtask

  task automatic test_addi();
    drive(32'h2002FFFC, 1); step();
    vectors++;
    if ({ex_valid, ex_immed, ex_alu_src, ex_reg_write, ex_alu_op, ex_rt} !==
        {1'b1, 32'hFFFFFFFC, 1'b1, 1'b1, 3'd0, 5'd2}) begin
      miscompares++;
      $display("FAIL addi_decode: got v=%b imm=%h as=%b rw=%b op=%0d rt=%0d", ex_valid,
               ex_immed, ex_alu_src, ex_reg_write, ex_alu_op, ex_rt);
    end
    vectors++;
    if (masked(observed()) !== masked(m)) begin
      miscompares++; $display("FAIL addi_model: got %h want %h", observed(), m);
    end
  endtask

  task automatic test_load_use();
    drive(32'h8C250000, 1); step();               // lw $5,0($1)
    drive(32'h00A73020, 1); step();               // add $6,$5,$7 -> stalls
    vectors++;
    if (seen_stall !== 1'b1) begin
      miscompares++; $display("FAIL lu_stall: got %b want 1", seen_stall);
    end
    vectors++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
      miscompares++; $display("FAIL lu_bubble: got v=%b rw=%b want 0 0", ex_valid, ex_reg_write);
    end
    step();                                       // IF/ID held the add
    vectors++;
    if (seen_stall !== 1'b0) begin
      miscompares++; $display("FAIL lu_release: got %b want 0", seen_stall);
    end
    vectors++;
    if (ex_valid !== 1'b1 || ex_rs !== 5'd5 || ex_reg_dst !== 1'b1) begin
      miscompares++; $display("FAIL lu_add: got v=%b rs=%0d rdst=%b want 1 5 1", ex_valid, ex_rs, ex_reg_dst);
    end
  endtask

  task automatic test_andi();
    logic [31:0] want;
`ifdef ZERO_EXT_LOGICAL_EN
    want = 32'h0000F000;
`else
    want = 32'hFFFFF000;
`endif
    drive(32'h3042F000, 1); step();
    vectors++;
    if (ex_immed !== want || ex_alu_op !== 3'd2) begin
      miscompares++; $display("FAIL andi_immed: got %h op=%0d want %h op=2", ex_immed, ex_alu_op, want);
    end
  endtask

  task automatic test_hold_flush();
    st_t snap;
    drive(32'h10220003, 1); step();               // beq $1,$2,3
    snap = observed();
    vectors++;
    if (ex_branch !== 1'b1 || ex_alu_op !== 3'd1) begin
      miscompares++; $display("FAIL beq_decode: got br=%b op=%0d want 1 1", ex_branch, ex_alu_op);
    end
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      drive($urandom, 1); step();
      vectors++;
      if (seen_stall !== 1'b1 || observed() !== snap) begin
        miscompares++; $display("FAIL hold_%0d: stall=%b got %h want %h", i, seen_stall, observed(), snap);
      end
    end
    hold = 0;
    drive(32'h8C630000, 1); step();               // lw $3,0($3)
    drive(32'h00631020, 1); flush = 1; step();    // dependent add with flush
    flush = 0;
    vectors++;
    if (seen_stall !== 1'b0 || ex_valid !== 1'b0 || ex_mem_read !== 1'b0) begin
      miscompares++; $display("FAIL flush_hazard: stall=%b v=%b mr=%b want 0 0 0", seen_stall, ex_valid, ex_mem_read);
    end
    drive(32'h2002FFFC, 1); step();
    drive(32'h20040001, 1); hold = 1; flush = 1; step();
    vectors++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
      miscompares++; $display("FAIL hold_flush: got v=%b rw=%b want 0 0", ex_valid, ex_reg_write);
    end
    flush = 0; drive(32'h20040001, 1); step();     // hold still set; then reset mid-hold
    rst = 1; step(); rst = 0; hold = 0;
    vectors++;
    if (observed() !== st_t'('0)) begin
      miscompares++; $display("FAIL reset_in_hold: got %h want 0", observed());
    end
  endtask

  task automatic test_zero_and_illegal();
    drive(32'h8C200000, 1); step();               // lw $0,0($1)
    drive(32'h00001020, 1); step();               // add $2,$0,$0
    vectors++;
    if (seen_stall !== 1'b0 || ex_valid !== 1'b1) begin
      miscompares++; $display("FAIL zero_reg: stall=%b v=%b want 0 1", seen_stall, ex_valid);
    end
    drive(32'hFC000000, 1); step();
    vectors++;
    if (ex_illegal !== 1'b1 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0) begin
      miscompares++; $display("FAIL illegal: ill=%b rw=%b mw=%b want 1 0 0", ex_illegal, ex_reg_write, ex_mem_write);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [10] = '{6'h00, 6'h02, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h23, 6'h3F};
    logic [31:0] ins;
    logic held = 0;
    for (int n = 0; n < 400; n++) begin
      if (!held) begin
        ins = $urandom;
        ins[31:26] = ops[$urandom_range(0, 9)];
        ins[25:21] = 5'($urandom_range(0, 3));
        ins[20:16] = 5'($urandom_range(0, 3));
        drive(ins, $urandom_range(0, 7) != 0);
      end else begin
        rs_data = $urandom; rt_data = $urandom;
      end
      hold  = $urandom_range(0, 9) == 0;
      flush = $urandom_range(0, 11) == 0;
      rst   = $urandom_range(0, 99) == 0;
      step();
      held = exp_stall;
      vectors++;
      if (seen_stall !== exp_stall || seen_addr !== instr[25:16]) begin
        miscompares++;
        $display("FAIL rnd_comb_%0d: stall=%b addr=%h want %b %h", n, seen_stall, seen_addr, exp_stall, instr[25:16]);
      end
      vectors++;
      if (masked(observed()) !== masked(m)) begin
        miscompares++; $display("FAIL rnd_latch_%0d: got %h want %h", n, masked(observed()), masked(m));
      end
    end
    rst = 0; hold = 0; flush = 0;
  endtask

  initial begin
    m = '0;
    rst = 1; hold = 0; flush = 0; if_valid = 0;
    instr = '0; pc_plus4 = '0; rs_data = '0; rt_data = '0;
    @(negedge clk);
    test_reset();
    test_addi();
    test_load_use();
    test_andi();
    test_hold_flush();
    test_zero_and_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode stage and ID/EX pipeline register for the pipelined MIPS-lite core. Takes the IF/ID instruction and register-file read data, generates control signals and the 32-bit extended immediate, and detects load-use hazards. Registers everything into the ID/EX latch consumed by EX. Handles flush (taken branch/jump), external hold, and bubble insertion.

## Interface
- No parameters.
- clk  in  1  core clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_valid  in  1  IF/ID holds a real instruction
- instr  in  32  IF/ID instruction word
- pc_plus4  in  32  IF/ID PC+4
- rs_data, rt_data  in  32 each  register-file read data (combinational, addressed by rs_addr/rt_addr)
- flush  in  1  taken branch/jump resolved downstream; kill the decoding instruction
- hold  in  1  downstream memory busy; freeze ID/EX
- rs_addr, rt_addr  out  5 each  instr[25:21], instr[20:16], combinational
- stall_out  out  1  combinational; IF must hold PC and IF/ID
- ex_valid  out  1  ID/EX holds a real instruction
- ex_pc_plus4, ex_rs_data, ex_rt_data, ex_immed  out  32 each
- ex_rs, ex_rt, ex_rd  out  5 each
- ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_alu_src, ex_reg_dst, ex_mem_to_reg, ex_illegal  out  1 each
- ex_alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 7 FUNCT (EX decodes funct)

## Operation
- Opcodes: R-type 0x00, j 0x02, beq 0x04, addi 0x08, andi 0x0C, ori 0x0D, lw 0x23, sw 0x2B. Any other opcode: all writes/mem controls 0, ex_illegal=1.
- Control: R-type reg_dst=1, reg_write=1, alu_op=FUNCT. lw alu_src, mem_read, mem_to_reg, reg_write, ADD. sw alu_src, mem_write, ADD. beq branch, SUB. addi ADD, andi AND, ori OR, all with alu_src, reg_write. j jump=1, nothing else.
- ex_immed: instr[15] replicated into [31:16], instr[15:0] in [15:0]; andi/ori exception under Configuration.
- Load-use hazard: ex_valid & ex_mem_read & ex_rt!=0 & if_valid & (ex_rt==rs | (uses_rt & ex_rt==rt)); uses_rt true for R-type, beq, sw.
- Next-state priority per edge: rst > flush > hold > hazard > load.
  - rst or flush: bubble (ex_valid=0, every control 0, ex_illegal=0).
  - hold: ID/EX unchanged.
  - hazard: bubble inserted; IF/ID held by stall_out.
  - otherwise: load decoded instr; ex_valid=if_valid; controls forced 0 when if_valid=0.
- stall_out = hold | (hazard & ~flush). Forced 0 during flush.
- Reset: all outputs 0, including data fields.

## Timing
- Decode-to-ID/EX latency: 1 cycle.
- lw followed directly by a dependent instruction: exactly one bubble. The dependent instruction enters ID/EX one cycle late.
- flush and hazard in the same cycle: bubble, stall_out=0.
- hold and flush in the same cycle: flush wins.
- Reset asserted mid-hold: bubble on that edge.
- rs/rt = $0 never hazards.

## Configuration
- ZERO_EXT_LOGICAL_EN defined: andi/ori use ex_immed = {16'h0, instr[15:0]}.
- Undefined: every immediate is sign-extended.

## Structure
- Package mips_lite_pkg holds:
  - opcode and alu_op localparams
  - typedef id_ex_ctrl_t (packed control struct)
  - BUBBLE constant of that type
- Sub-module immed_extend: 16-bit in, zero_sel in, 32-bit out. Purely combinational.

## Test plan
- rst=1 for 2 cycles -> every output 0, stall_out=0.
- instr 0x2002FFFC (addi $2,$0,-4) -> next cycle ex_immed 0xFFFFFFFC, alu_src=1, reg_write=1, alu_op=0, ex_rt=2.
- lw $5,0($1) then add $6,$5,$7 -> stall_out=1 for one cycle, one bubble (ex_valid=0), then add in ID/EX with ex_rs=5.
- instr 0x3042F000 (andi) -> ex_immed 0x0000F000 with ZERO_EXT_LOGICAL_EN, 0xFFFFF000 without.
- hold=1 for 3 cycles after beq loaded -> ID/EX unchanged, stall_out=1. flush=1 with hazard present -> bubble, stall_out=0.
- opcode 0x3F -> ex_illegal=1, reg_write/mem_write=0.
